// File: rtl/issue_queue_pkg.sv
// Shared types for the dispatch-to-issue instruction queue.
// iq_entry_t pairs a decoded instruction with its ROB slot.
package issue_queue_pkg;

   localparam int IQ_DEPTHLOG2 = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [6:0]  opcode;
      logic [4:0]  rd;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
   } dec_inst_t;

   typedef struct packed {
      dec_inst_t  inst;
      logic [5:0] rob_slot;
   } iq_entry_t;

endpackage

// File: rtl/issue_queue_ram.sv
// Entry storage: multi-write-port register array with asynchronous read ports.
// Addresses arrive already wrapped; write addresses within a cycle are distinct.
module issue_queue_ram
   import issue_queue_pkg::*;
#(
   parameter int AW = 4,
   parameter int NW = 2,
   parameter int NR = 4
) (
   input  logic            clock,
   input  logic [NW-1:0]   we,
   input  logic [AW-1:0]   waddr [NW],
   input  iq_entry_t       wdata [NW],
   input  logic [AW-1:0]   raddr [NR],
   output iq_entry_t       rdata [NR]
);

   iq_entry_t mem [2**AW];

   // Storage is deliberately not reset; readers qualify with ext_valid.
   always_ff @(posedge clock) begin
      for (int k = 0; k < NW; k++) begin
         if (we[k]) mem[waddr[k]] <= wdata[k];
      end
   end

   always_comb begin
      for (int i = 0; i < NR; i++) begin
         rdata[i] = mem[raddr[i]];
      end
   end

endmodule

// File: rtl/issue_queue.sv
// In-order issue queue: up to INSERT_PER_CYCLE inserts and 1..ISSUE_PER_CYCLE
// retires per cycle, full flush on branch. count is the sole full/empty authority.
module issue_queue
   import issue_queue_pkg::*;
#(
   parameter int DEPTHLOG2        = IQ_DEPTHLOG2,
   parameter int ISSUE_PER_CYCLE  = 4,
   parameter int INSERT_PER_CYCLE = 2,
   parameter int ISS_PC_LOG2      = $clog2(ISSUE_PER_CYCLE)
) (
   input  logic                        clock,
   input  logic                        reset,
   input  logic [INSERT_PER_CYCLE-1:0] ins_valid,
   input  iq_entry_t                   ins_entries [INSERT_PER_CYCLE],
   output logic                        ins_ready,
   input  logic                        ext_enable,
   input  logic [ISS_PC_LOG2-1:0]      ext_consumed,
   output logic [ISSUE_PER_CYCLE-1:0]  ext_valid,
   output iq_entry_t                   insns [ISSUE_PER_CYCLE],
   output logic                        empty,
   input  logic                        flush,
   output logic [DEPTHLOG2:0]          count
);

   localparam int DEPTH = 2**DEPTHLOG2;
   localparam int CW    = DEPTHLOG2 + 1;

   // Handshake: an insert is accepted at an edge only when ins_ready (from the
   // registered count) was high; issue retires ext_consumed+1 entries at an edge
   // with ext_enable high, having taken them from insns during that cycle.
   logic [DEPTHLOG2-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0]        free_slots, n_lead, n_ins, n_cons_req, n_cons;
   logic                 lead_run;
   logic [INSERT_PER_CYCLE-1:0] we;
   logic [DEPTHLOG2-1:0] waddr [INSERT_PER_CYCLE];
   logic [DEPTHLOG2-1:0] raddr [ISSUE_PER_CYCLE];

   // Only the leading contiguous run of valid slots counts as inserted.
   always_comb begin
      n_lead   = '0;
      lead_run = 1'b1;
      for (int k = 0; k < INSERT_PER_CYCLE; k++) begin
         lead_run = lead_run & ins_valid[k];
         if (lead_run) n_lead = n_lead + CW'(1);
      end
   end

   assign free_slots = CW'(DEPTH) - count;
   assign ins_ready  = free_slots >= CW'(INSERT_PER_CYCLE);
   assign n_ins      = ins_ready ? n_lead : '0;
   assign n_cons_req = CW'(ext_consumed) + CW'(1);
   assign n_cons     = !ext_enable ? '0 : ((n_cons_req > count) ? count : n_cons_req);
   assign empty      = (count == '0);

   always_comb begin
      for (int k = 0; k < INSERT_PER_CYCLE; k++) begin
         we[k]    = !flush && ins_ready && (CW'(k) < n_lead);
         waddr[k] = wr_ptr + DEPTHLOG2'(k);
      end
      for (int i = 0; i < ISSUE_PER_CYCLE; i++) begin
         raddr[i]     = rd_ptr + DEPTHLOG2'(i);
         ext_valid[i] = count > CW'(i);
      end
   end

   issue_queue_ram #(
      .AW (DEPTHLOG2),
      .NW (INSERT_PER_CYCLE),
      .NR (ISSUE_PER_CYCLE)
   ) u_ram (
      .clock (clock),
      .we    (we),
      .waddr (waddr),
      .wdata (ins_entries),
      .raddr (raddr),
      .rdata (insns)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (flush) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         rd_ptr <= rd_ptr + n_cons[DEPTHLOG2-1:0];
         wr_ptr <= wr_ptr + n_ins[DEPTHLOG2-1:0];
         count  <= count + n_ins - n_cons;
      end
   end

`ifndef SYNTHESIS
   always @(posedge clock) begin
      if (!reset && !flush) begin
         if (ext_enable)
            assert (n_cons_req <= count)
               else $warning("issue_queue: consume of %0d exceeds count %0d, clamped", n_cons_req, count);
         if (|ins_valid)
            assert (ins_ready)
               else $warning("issue_queue: insert while not ready, dropped");
         assert ((ins_valid & (ins_valid + 1'b1)) == '0)
            else $warning("issue_queue: non-contiguous ins_valid %b", ins_valid);
      end
   end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: vector table, directed corner sequences, and random
// traffic checked against a queue-based reference model.
module tb_issue_queue;
   import issue_queue_pkg::*;

   logic        clock = 1'b0;
   logic        reset = 1'b0;
   logic [1:0]  ins_valid = '0;
   iq_entry_t   ins_entries [2];
   logic        ins_ready;
   logic        ext_enable = 1'b0;
   logic [1:0]  ext_consumed = '0;
   logic [3:0]  ext_valid;
   iq_entry_t   insns [4];
   logic        empty;
   logic        flush = 1'b0;
   logic [4:0]  count;

   issue_queue dut (
      .clock        (clock),
      .reset        (reset),
      .ins_valid    (ins_valid),
      .ins_entries  (ins_entries),
      .ins_ready    (ins_ready),
      .ext_enable   (ext_enable),
      .ext_consumed (ext_consumed),
      .ext_valid    (ext_valid),
      .insns        (insns),
      .empty        (empty),
      .flush        (flush),
      .count        (count)
   );

   always #5 clock = ~clock;

   typedef struct {
      logic [1:0] v;
      logic       en;
      logic [1:0] c;
      logic       f;
      int         exp_count;
      logic       exp_ready;
      logic [3:0] exp_ev;
   } vec_t;

   iq_entry_t model_q [$];
   iq_entry_t drv_ent [2];
   iq_entry_t saved;
   int        n_checks = 0;
   int        n_errors = 0;
   int        serial = 0;
   vec_t      tbl [10];

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic iq_entry_t rand_entry();
      iq_entry_t e;
      serial++;
      e.inst.pc     = 32'(serial);
      e.inst.opcode = 7'($urandom);
      e.inst.rd     = 5'($urandom);
      e.inst.rs1    = 5'($urandom);
      e.inst.rs2    = 5'($urandom);
      e.rob_slot    = 6'($urandom);
      return e;
   endfunction

   task automatic compare_model();
      int sz;
      logic [3:0] ev;
      sz = model_q.size();
      for (int i = 0; i < 4; i++) ev[i] = (sz > i);
      chk("count", 64'(count), 64'(sz));
      chk("empty", 64'(empty), 64'(sz == 0));
      chk("ins_ready", 64'(ins_ready), 64'((16 - sz) >= 2));
      chk("ext_valid", 64'(ext_valid), 64'(ev));
      for (int i = 0; i < 4 && i < sz; i++)
         chk($sformatf("insns[%0d]", i), 64'(insns[i]), 64'(model_q[i]));
   endtask

   // One clock of traffic: drive, update the reference at the edge, compare.
   task automatic step(input logic [1:0] v, input logic en, input logic [1:0] c, input logic f);
      int sz, nc, ni;
      ins_valid = v; ext_enable = en; ext_consumed = c; flush = f;
      for (int k = 0; k < 2; k++) begin
         drv_ent[k] = rand_entry();
         ins_entries[k] = drv_ent[k];
      end
      @(posedge clock);
      if (f) begin
         model_q.delete();
      end else begin
         sz = model_q.size();
         nc = 0;
         if (en) nc = (int'(c) + 1 > sz) ? sz : int'(c) + 1;
         ni = 0;
         if ((16 - sz) >= 2) begin
            for (int k = 0; k < 2; k++) begin
               if (v[k] && ni == k) ni++;
            end
         end
         repeat (nc) void'(model_q.pop_front());
         for (int k = 0; k < ni; k++) model_q.push_back(drv_ent[k]);
      end
      #1;
      ins_valid = '0; ext_enable = 1'b0; ext_consumed = '0; flush = 1'b0;
      compare_model();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      #3;
      reset = 1'b0;
      model_q.delete();
   endtask

   initial begin
      int sz, r;
      logic [1:0] rv, rc;
      logic       ren;
      for (int k = 0; k < 2; k++) ins_entries[k] = '0;

      #1 reset = 1'b1;
      #2;
      chk("reset_count", 64'(count), 64'd0);
      chk("reset_empty", 64'(empty), 64'd1);
      chk("reset_ready", 64'(ins_ready), 64'd1);
      chk("reset_ev", 64'(ext_valid), 64'd0);
      #1 reset = 1'b0;

      tbl[0] = '{2'b11, 1'b0, 2'd0, 1'b0, 2, 1'b1, 4'b0011};
      tbl[1] = '{2'b01, 1'b0, 2'd0, 1'b0, 3, 1'b1, 4'b0111};
      tbl[2] = '{2'b11, 1'b1, 2'd0, 1'b0, 4, 1'b1, 4'b1111};
      tbl[3] = '{2'b00, 1'b1, 2'd3, 1'b0, 0, 1'b1, 4'b0000};
      tbl[4] = '{2'b11, 1'b0, 2'd0, 1'b0, 2, 1'b1, 4'b0011};
      tbl[5] = '{2'b00, 1'b1, 2'd2, 1'b0, 0, 1'b1, 4'b0000};
      tbl[6] = '{2'b11, 1'b0, 2'd0, 1'b0, 2, 1'b1, 4'b0011};
      tbl[7] = '{2'b11, 1'b1, 2'd1, 1'b1, 0, 1'b1, 4'b0000};
      tbl[8] = '{2'b10, 1'b0, 2'd0, 1'b0, 0, 1'b1, 4'b0000};
      tbl[9] = '{2'b01, 1'b0, 2'd0, 1'b0, 1, 1'b1, 4'b0001};
      for (int i = 0; i < 10; i++) begin
         step(tbl[i].v, tbl[i].en, tbl[i].c, tbl[i].f);
         chk($sformatf("tbl%0d_count", i), 64'(count), 64'(tbl[i].exp_count));
         chk($sformatf("tbl%0d_ready", i), 64'(ins_ready), 64'(tbl[i].exp_ready));
         chk($sformatf("tbl%0d_ev", i), 64'(ext_valid), 64'(tbl[i].exp_ev));
      end

      // Asynchronous reset in the middle of a cycle with 5 entries held.
      step(2'b11, 1'b0, 2'd0, 1'b0);
      step(2'b11, 1'b0, 2'd0, 1'b0);
      chk("midrst_pre_count", 64'(count), 64'd5);
      #2 reset = 1'b1;
      #1;
      chk("midrst_empty", 64'(empty), 64'd1);
      chk("midrst_count", 64'(count), 64'd0);
      chk("midrst_ev", 64'(ext_valid), 64'd0);
      chk("midrst_ready", 64'(ins_ready), 64'd1);
      #1 reset = 1'b0;
      model_q.delete();

      // Fill to full, then an extra insert must be dropped.
      for (int i = 0; i < 8; i++) begin
         step(2'b11, 1'b0, 2'd0, 1'b0);
         chk("fill_ready", 64'(ins_ready), 64'(2 * (i + 1) <= 14));
      end
      chk("full_count", 64'(count), 64'd16);
      step(2'b11, 1'b0, 2'd0, 1'b0);
      chk("overfill_count", 64'(count), 64'd16);

      // Move the pointers to 14 so four entries straddle the wrap point.
      apply_reset();
      repeat (7) step(2'b11, 1'b0, 2'd0, 1'b0);
      repeat (3) step(2'b00, 1'b1, 2'd3, 1'b0);
      step(2'b00, 1'b1, 2'd1, 1'b0);
      chk("wrap_drained", 64'(count), 64'd0);
      step(2'b11, 1'b0, 2'd0, 1'b0);
      step(2'b11, 1'b0, 2'd0, 1'b0);
      saved = drv_ent[1];
      chk("wrap_count", 64'(count), 64'd4);
      step(2'b00, 1'b1, 2'd2, 1'b0);
      chk("wrap_cons_count", 64'(count), 64'd1);
      chk("wrap_insns0", 64'(insns[0]), 64'(saved));

      // Insert 2 while consuming all 3 held entries.
      step(2'b01, 1'b0, 2'd0, 1'b0);
      step(2'b01, 1'b0, 2'd0, 1'b0);
      chk("simul_pre", 64'(count), 64'd3);
      step(2'b11, 1'b1, 2'd2, 1'b0);
      chk("simul_count", 64'(count), 64'd2);
      chk("simul_ev", 64'(ext_valid), 64'b0011);
      chk("simul_insns0", 64'(insns[0]), 64'(drv_ent[0]));
      chk("simul_insns1", 64'(insns[1]), 64'(drv_ent[1]));

      // Flush with concurrent insert and consume at count 7.
      step(2'b11, 1'b0, 2'd0, 1'b0);
      step(2'b11, 1'b0, 2'd0, 1'b0);
      step(2'b01, 1'b0, 2'd0, 1'b0);
      chk("flush_pre", 64'(count), 64'd7);
      step(2'b11, 1'b1, 2'd1, 1'b1);
      chk("flush_count", 64'(count), 64'd0);
      chk("flush_empty", 64'(empty), 64'd1);
      step(2'b00, 1'b0, 2'd0, 1'b0);
      chk("flush_after_ev", 64'(ext_valid), 64'd0);

      // Over-consume clamps to the occupancy.
      step(2'b11, 1'b0, 2'd0, 1'b0);
      chk("partial_ev", 64'(ext_valid), 64'b0011);
      step(2'b00, 1'b1, 2'd2, 1'b0);
      chk("clamp_count", 64'(count), 64'd0);

      // Random legal traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         sz = model_q.size();
         rv = 2'b00;
         if ((16 - sz) >= 2) begin
            r = $urandom_range(0, 2);
            rv = (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
         end
         ren = (sz > 0) && ($urandom_range(0, 1) == 1);
         rc = 2'(ren ? $urandom_range(0, ((sz > 4) ? 4 : sz) - 1) : 0);
         step(rv, ren, rc, $urandom_range(0, 31) == 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Multi-port in-order instruction queue between dispatch (decode + ROB slot allocation) and the issue stage.
- Accepts up to INSERT_PER_CYCLE iq_entry_t entries per cycle and always presents the oldest ISSUE_PER_CYCLE entries to issue.
- Retires 1..ISSUE_PER_CYCLE entries per cycle on issue's consume handshake.
- Flushes completely on a taken/mispredicted branch.

Parameters:
- DEPTHLOG2, 4, log2 of queue depth (DEPTH = 16 entries).
- ISSUE_PER_CYCLE, 4, read ports presented to issue.
- INSERT_PER_CYCLE, 2, write ports from dispatch.
- ISS_PC_LOG2, $clog2(ISSUE_PER_CYCLE), width of ext_consumed.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- ins_valid  in  1 x INSERT_PER_CYCLE  per-slot insert request; contiguous from slot 0.
- ins_entries  in  iq_entry_t x INSERT_PER_CYCLE  entries to insert; slot 0 is oldest.
- ins_ready  out  1  free space >= INSERT_PER_CYCLE.
- ext_enable  in  1  issue consumes entries this cycle.
- ext_consumed  in  ISS_PC_LOG2  number consumed minus 1.
- ext_valid  out  1 x ISSUE_PER_CYCLE  ext_valid[i] = (count > i).
- insns  out  iq_entry_t x ISSUE_PER_CYCLE  insns[i] = mem[rd_ptr+i mod DEPTH].
- empty  out  1  count == 0.
- flush  in  1  branch flush from issue.
- count  out  DEPTHLOG2+1  current occupancy.

Behaviour:
- **Storage and pointers:** circular buffer of DEPTH entries; rd_ptr and wr_ptr are DEPTHLOG2 bits and wrap modulo DEPTH; count is DEPTHLOG2+1 bits, range 0..DEPTH.
- **Reset (async, asserted high):** rd_ptr = wr_ptr = 0, count = 0. Outputs then read empty = 1, ext_valid all 0, ins_ready = 1, count = 0. Entry storage is not reset; insns contents are don't-care while the matching ext_valid = 0.
- **Read side:** purely combinational from registered state, zero latency. insns/ext_valid update the cycle after any pointer change.
- **Consume:** on a clock edge with ext_enable = 1, n_cons = ext_consumed + 1.
  - rd_ptr += n_cons, count -= n_cons.
  - n_cons > count is a protocol violation: flag it with a simulation assertion; RTL clamps n_cons to count.
- **Insert:** n_ins = number of asserted ins_valid.
  - Entry k is written at wr_ptr + k; then wr_ptr += n_ins, count += n_ins.
  - Inserting while ins_ready = 0 is a protocol violation: assertion fires; RTL drops all inserts that cycle.
  - Non-contiguous ins_valid: assertion fires; only the leading contiguous run is written.
- **Simultaneous insert and consume:** both apply in the same edge; count_next = count + n_ins - n_cons. ins_ready is computed from the registered count only (conservative, no same-cycle bypass of freed space).
- **Write-to-read latency:** 1 cycle; an entry inserted at edge t is visible on insns at t+1. No bypass into the current cycle's read ports.
- **Full/empty boundaries:**
  - count = DEPTH means full, rd_ptr == wr_ptr, ins_ready = 0.
  - count = 0 means empty, rd_ptr == wr_ptr.
  - Pointer equality is never used to infer full/empty; count is authoritative.
- **Flush (highest priority):** at an edge with flush = 1:
  - rd_ptr <= 0, wr_ptr <= 0, count <= 0.
  - Same-cycle inserts are discarded.
  - Same-cycle consume is irrelevant: issue has already taken the branch and its delay slot in that cycle.
  - Next cycle: empty = 1, ins_ready = 1.
- **Flush together with reset:** reset dominates (identical result).
- **No internal state machine** beyond the pointers/count: state is {count == 0, 0 < count < DEPTH, count == DEPTH}, updated as above.

Decomposition:
- iq_entry_t (dec_inst_t + rob_slot) stays in pipTypes. Add nothing new to the package except, optionally, an IQ_DEPTHLOG2 localparam default.
- One natural sub-module: issue_queue_ram, a DEPTH x iq_entry_t register array with INSERT_PER_CYCLE write ports and ISSUE_PER_CYCLE asynchronous read ports, indexed by pre-wrapped addresses.
- Pointer/count control lives in issue_queue.

Test Plan:
1. Reset mid-operation: fill 5 entries, assert reset asynchronously -> empty = 1, count = 0, ext_valid = 0000 immediately, ins_ready = 1.
2. Insert 2/cycle for 8 cycles with no consume -> count reaches 16, ins_ready = 0 after count >= 15. A 9th insert attempt fires the assertion and count stays 16.
3. Wrap-around: rd_ptr = 14, count = 4 (entries at 14, 15, 0, 1) -> insns[0..3] show slots 14, 15, 0, 1. Consume ext_consumed = 2 -> next cycle count = 1, insns[0] = old slot 1.
4. Simultaneous: count = 3, insert 2, consume 3 (ext_consumed = 2) -> count = 2, insns[0..1] = the inserted entries in order, ext_valid = 0011.
5. Flush with concurrent insert and consume: count = 7, flush = 1, ins_valid = 11, ext_enable = 1 -> next cycle count = 0, empty = 1. Inserted entries are absent on the following cycle.
6. Partial visibility: count = 2 -> ext_valid = 0011. Consume of 3 (ext_consumed = 2) fires the assertion and clamps, giving count = 0.
